// File: rtl/splitter.sv
// Splitter: re-enqueues one spilled chunk slot of tasks and returns fully drained chunks to the splitter stack.
// Optional build macro SPLITTER_STATS_EN adds split/task/free counters on the register bus.
module splitter #(
    parameter int CORE_ID = 3,
    parameter int TILE_ID = 0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        l1_arvalid,
    input  logic        l1_arready,
    output logic [31:0] l1_araddr,
    output logic [7:0]  l1_arlen,
    output logic [2:0]  l1_arsize,
    output logic [3:0]  l1_arid,
    input  logic        l1_rvalid,
    output logic        l1_rready,
    input  logic [63:0] l1_rdata,
    input  logic        l1_rlast,
    output logic        l1_awvalid,
    input  logic        l1_awready,
    output logic [31:0] l1_awaddr,
    output logic [7:0]  l1_awlen,
    output logic [2:0]  l1_awsize,
    output logic [3:0]  l1_awid,
    output logic        l1_wvalid,
    output logic [63:0] l1_wdata,
    output logic [7:0]  l1_wstrb,
    output logic        l1_wlast,
    input  logic        l1_bvalid,
    output logic        l1_bready,
    input  logic        reg_wvalid,
    input  logic [7:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_arvalid,
    input  logic [7:0]  reg_araddr,
    output logic        reg_rvalid,
    output logic [31:0] reg_rdata,
    input  logic        task_in_valid,
    output logic        task_in_ready,
    input  logic [63:0] task_in,
    output logic        task_out_valid,
    input  logic        task_out_ready,
    output logic [63:0] task_out,
    output logic        stack_lock_out,
    input  logic        stack_lock_in
);
    localparam int TQ_WIDTH                       = 64;
    localparam int TASKS_PER_SPLITTER             = 8;
    localparam int LOG_SPLITTERS_PER_CHUNK        = 3;
    localparam int LOG_SPLITTER_CHUNK_WIDTH       = 6;
    localparam int LOG_SPLITTER_STACK_ENTRY_WIDTH = 4;
    localparam int SLOTS                          = 2 ** LOG_SPLITTERS_PER_CHUNK;

    localparam logic [7:0] CORE_START            = 8'h00;
    localparam logic [7:0] CORE_STATE            = 8'h04;
    localparam logic [7:0] CORE_NUM_ENQ          = 8'h08;
    localparam logic [7:0] CORE_NUM_DEQ          = 8'h0C;
    localparam logic [7:0] CORE_STAT_0           = 8'h10;
    localparam logic [7:0] SPILL_BASE_TASKS      = 8'h20;
    localparam logic [7:0] SPILL_BASE_STACK      = 8'h24;
    localparam logic [7:0] SPILL_BASE_SCRATCHPAD = 8'h28;
    localparam logic [7:0] SPILL_ADDR_STACK_PTR  = 8'h2C;

    // state        | meaning
    // IDLE         | wait for a splitter task (only while started)
    // RD_TASKS     | issue burst read of the slot's task records
    // RD_DATA      | stream records straight to task_out
    // RD_SCR(_WAIT)| read the chunk's done bitmap
    // WR_SCR(_WAIT)| write merged bitmap, zero if chunk complete
    // GRAB/CHECK   | acquire stack lock, one settle cycle
    // RD_PTR(_WAIT)| read stack pointer
    // WR_ENTRY(_W) | push chunk id at ptr-1
    // WR_PTR(_WAIT)| store ptr-1
    // RELEASE      | drop stack lock
    typedef enum logic [3:0] {
        IDLE, RD_TASKS, RD_DATA, RD_SCR, RD_SCR_WAIT, WR_SCR, WR_SCR_WAIT, GRAB,
        CHECK, RD_PTR, RD_PTR_WAIT, WR_ENTRY, WR_ENTRY_WAIT, WR_PTR, WR_PTR_WAIT, RELEASE
    } state_t;

    state_t      state, state_nx;
    logic        start, err_underflow;
    logic [15:0] coal_id, chunk, ptr, ptr_m1;
    logic [31:0] scr_word, spill_base, stack_base, scr_base, ptr_addr, scr_addr, rd_mux;
    logic        chunk_full, task_hs;

    assign chunk      = coal_id >> LOG_SPLITTERS_PER_CHUNK;
    assign ptr_m1     = ptr - 16'd1;
    assign scr_addr   = scr_base + ({16'b0, chunk} << 2);
    assign chunk_full = &scr_word[SLOTS-1:0];
    assign task_hs    = (state == IDLE) && start && task_in_valid;
    assign task_out   = l1_rdata[TQ_WIDTH-1:0];
    assign l1_arid    = 4'd0;
    assign l1_awid    = 4'd0;
    assign l1_awlen   = 8'd0;
    assign l1_wlast   = 1'b1;
    assign l1_wvalid  = l1_awvalid;

    logic unused_ok;
    assign unused_ok = ^{task_in[63:32], task_in[15:0], reg_wdata[31:26]} ^ TILE_ID[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        task_in_ready  = 1'b0;
        task_out_valid = 1'b0;
        l1_arvalid     = 1'b0;
        l1_araddr      = '0;
        l1_arlen       = '0;
        l1_arsize      = '0;
        l1_rready      = 1'b0;
        l1_awvalid     = 1'b0;
        l1_awaddr      = '0;
        l1_awsize      = '0;
        l1_wdata       = '0;
        l1_wstrb       = '0;
        l1_bready      = 1'b0;
        case (state)
            IDLE: begin
                task_in_ready = start;
                if (task_hs) state_nx = RD_TASKS;
            end
            RD_TASKS: begin
                l1_arvalid = 1'b1;
                l1_araddr  = spill_base + ({16'b0, coal_id} << LOG_SPLITTER_CHUNK_WIDTH);
                l1_arlen   = 8'(TASKS_PER_SPLITTER - 1);
                l1_arsize  = 3'($clog2(TQ_WIDTH) - 3);
                if (l1_arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                task_out_valid = l1_rvalid;
                l1_rready      = task_out_ready;
                if (l1_rvalid && task_out_ready && l1_rlast) state_nx = RD_SCR;
            end
            RD_SCR: begin
                l1_arvalid = 1'b1;
                l1_araddr  = scr_addr;
                l1_arsize  = 3'd2;
                if (l1_arready) state_nx = RD_SCR_WAIT;
            end
            RD_SCR_WAIT: begin
                l1_rready = 1'b1;
                if (l1_rvalid) state_nx = WR_SCR;
            end
            WR_SCR: begin
                l1_awvalid = 1'b1;
                l1_awaddr  = scr_addr;
                l1_awsize  = 3'd2;
                l1_wstrb   = 8'h0F;
                l1_wdata   = chunk_full ? 64'd0 : {32'd0, scr_word};
                if (l1_awready) state_nx = WR_SCR_WAIT;
            end
            WR_SCR_WAIT: begin
                l1_bready = 1'b1;
                if (l1_bvalid) state_nx = chunk_full ? GRAB : IDLE;
            end
            GRAB:  if (!stack_lock_in) state_nx = CHECK;
            CHECK: state_nx = RD_PTR;
            RD_PTR: begin
                l1_arvalid = 1'b1;
                l1_araddr  = ptr_addr;
                l1_arsize  = 3'd1;
                if (l1_arready) state_nx = RD_PTR_WAIT;
            end
            RD_PTR_WAIT: begin
                l1_rready = 1'b1;
                if (l1_rvalid) state_nx = (l1_rdata[15:0] == 16'd0) ? RELEASE : WR_ENTRY;
            end
            WR_ENTRY: begin
                l1_awvalid = 1'b1;
                l1_awaddr  = stack_base + ({16'b0, ptr_m1} << (LOG_SPLITTER_STACK_ENTRY_WIDTH - 3));
                l1_awsize  = 3'd1;
                l1_wstrb   = 8'h03;
                l1_wdata   = {48'd0, chunk};
                if (l1_awready) state_nx = WR_ENTRY_WAIT;
            end
            WR_ENTRY_WAIT: begin
                l1_bready = 1'b1;
                if (l1_bvalid) state_nx = WR_PTR;
            end
            WR_PTR: begin
                l1_awvalid = 1'b1;
                l1_awaddr  = ptr_addr;
                l1_awsize  = 3'd1;
                l1_wstrb   = 8'h03;
                l1_wdata   = {48'd0, ptr_m1};
                if (l1_awready) state_nx = WR_PTR_WAIT;
            end
            WR_PTR_WAIT: begin
                l1_bready = 1'b1;
                if (l1_bvalid) state_nx = RELEASE;
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start          <= 1'b0;
            spill_base     <= '0;
            stack_base     <= '0;
            scr_base       <= '0;
            ptr_addr       <= '0;
            coal_id        <= '0;
            scr_word       <= '0;
            ptr            <= '0;
            err_underflow  <= 1'b0;
            stack_lock_out <= 1'b0;
        end else begin
            if (reg_wvalid) begin
                case (reg_waddr)
                    CORE_START:            start      <= reg_wdata[CORE_ID];
                    SPILL_BASE_TASKS:      spill_base <= {reg_wdata[25:0], 6'b0};
                    SPILL_BASE_STACK:      stack_base <= {reg_wdata[25:0], 6'b0};
                    SPILL_BASE_SCRATCHPAD: scr_base   <= {reg_wdata[25:0], 6'b0};
                    SPILL_ADDR_STACK_PTR:  ptr_addr   <= {reg_wdata[25:0], 6'b0};
                    default: ;
                endcase
            end
            if (task_hs) coal_id <= task_in[31:16];
            if (state == RD_SCR_WAIT && l1_rvalid)
                scr_word <= l1_rdata[31:0] | (32'd1 << coal_id[LOG_SPLITTERS_PER_CHUNK-1:0]);
            if (state == RD_PTR_WAIT && l1_rvalid) begin
                ptr <= l1_rdata[15:0];
                if (l1_rdata[15:0] == 16'd0) err_underflow <= 1'b1;
            end
            // Coalescer backs off if it requests in the cycle we take the lock.
            if (state == GRAB && !stack_lock_in) stack_lock_out <= 1'b1;
            else if (state == RELEASE)           stack_lock_out <= 1'b0;
        end
    end

`ifdef SPLITTER_STATS_EN
    logic [31:0] num_splits, num_tasks, num_frees;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_splits <= '0;
            num_tasks  <= '0;
            num_frees  <= '0;
        end else begin
            if (task_hs) num_splits <= num_splits + 32'd1;
            if (task_out_valid && task_out_ready) num_tasks <= num_tasks + 32'd1;
            if (state == WR_PTR_WAIT && l1_bvalid) num_frees <= num_frees + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_araddr)
            CORE_STATE:   rd_mux = {27'd0, err_underflow, state};
`ifdef SPLITTER_STATS_EN
            CORE_NUM_DEQ: rd_mux = num_splits;
            CORE_NUM_ENQ: rd_mux = num_tasks;
            CORE_STAT_0:  rd_mux = num_frees;
`else
            CORE_NUM_DEQ, CORE_NUM_ENQ, CORE_STAT_0: rd_mux = '0;
`endif
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            reg_rvalid <= reg_arvalid;
            reg_rdata  <= rd_mux;
        end
    end
endmodule

// File: tb/tb_splitter.sv
// Scoreboard bench for splitter: AXI memory model, task_out monitor, directed slot/chunk/stack scenarios.
module tb_splitter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        l1_arvalid, l1_arready, l1_rvalid, l1_rready, l1_rlast;
    logic [31:0] l1_araddr, l1_awaddr;
    logic [7:0]  l1_arlen, l1_awlen, l1_wstrb;
    logic [2:0]  l1_arsize, l1_awsize;
    logic [3:0]  l1_arid, l1_awid;
    logic [63:0] l1_rdata, l1_wdata;
    logic        l1_awvalid, l1_awready, l1_wvalid, l1_wlast, l1_bvalid, l1_bready;
    logic        reg_wvalid = 0, reg_arvalid = 0, reg_rvalid;
    logic [7:0]  reg_waddr = 0, reg_araddr = 0;
    logic [31:0] reg_wdata = 0, reg_rdata;
    logic        task_in_valid = 0, task_in_ready, task_out_valid, task_out_ready = 1;
    logic [63:0] task_in = 0, task_out;
    logic        stack_lock_out, stack_lock_in = 0;

    splitter dut (
        .clk(clk), .rstn(rstn),
        .l1_arvalid(l1_arvalid), .l1_arready(l1_arready), .l1_araddr(l1_araddr), .l1_arlen(l1_arlen),
        .l1_arsize(l1_arsize), .l1_arid(l1_arid), .l1_rvalid(l1_rvalid), .l1_rready(l1_rready),
        .l1_rdata(l1_rdata), .l1_rlast(l1_rlast), .l1_awvalid(l1_awvalid), .l1_awready(l1_awready),
        .l1_awaddr(l1_awaddr), .l1_awlen(l1_awlen), .l1_awsize(l1_awsize), .l1_awid(l1_awid),
        .l1_wvalid(l1_wvalid), .l1_wdata(l1_wdata), .l1_wstrb(l1_wstrb), .l1_wlast(l1_wlast),
        .l1_bvalid(l1_bvalid), .l1_bready(l1_bready),
        .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr), .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
        .task_in_valid(task_in_valid), .task_in_ready(task_in_ready), .task_in(task_in),
        .task_out_valid(task_out_valid), .task_out_ready(task_out_ready), .task_out(task_out),
        .stack_lock_out(stack_lock_out), .stack_lock_in(stack_lock_in)
    );

    int n_chk = 0, n_fail = 0, n_hs = 0;
    logic [63:0] exp_q[$];
    logic [31:0] wl_addr[$];
    logic [63:0] wl_data[$];
    logic [63:0] mem [logic [31:0]];
    logic        lock_seen = 0, tog_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] task_val(input logic [31:0] a);
        return 64'hDEAD_0000_0000_0000 | {32'h0, a};
    endfunction

    // AXI memory model: one outstanding read burst, one outstanding write.
    logic        rd_busy, b_pend;
    logic [31:0] rd_addr;
    logic [7:0]  rd_left;
    logic [2:0]  rd_size;
    logic [63:0] wmask;
    assign l1_arready = !rd_busy;
    assign l1_rvalid  = rd_busy;
    assign l1_rlast   = rd_busy && (rd_left == 8'd0);
    assign l1_awready = !b_pend;
    assign l1_bvalid  = b_pend;
    assign wmask = (l1_awsize == 3'd1) ? 64'hFFFF : (l1_awsize == 3'd2) ? 64'hFFFF_FFFF : '1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_busy <= 0; rd_addr <= 0; rd_left <= 0; rd_size <= 0; l1_rdata <= 0; b_pend <= 0;
        end else begin
            if (l1_arvalid && l1_arready) begin
                rd_busy <= 1; rd_addr <= l1_araddr; rd_left <= l1_arlen; rd_size <= l1_arsize;
                l1_rdata <= rd_mem(l1_araddr);
            end else if (l1_rvalid && l1_rready) begin
                if (rd_left == 8'd0) rd_busy <= 0;
                else begin
                    rd_addr  <= rd_addr + (32'd1 << rd_size);
                    rd_left  <= rd_left - 8'd1;
                    l1_rdata <= rd_mem(rd_addr + (32'd1 << rd_size));
                end
            end
            if (l1_awvalid && l1_awready) begin
                mem[l1_awaddr] = l1_wdata & wmask;
                wl_addr.push_back(l1_awaddr);
                wl_data.push_back(l1_wdata & wmask);
                b_pend <= 1;
            end else if (l1_bvalid && l1_bready) b_pend <= 0;
            if (stack_lock_out) lock_seen = 1;
        end
    end

    // Monitor: every task_out handshake is popped from the scoreboard.
    always @(negedge clk) begin
        if (rstn && task_out_valid) begin
            chk("rready_mirror", {63'd0, l1_rready}, {63'd0, task_out_ready});
            if (task_out_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL task_out_extra: got %h, required no task", task_out);
                end else chk("task_out", task_out, exp_q.pop_front());
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (tog_en) task_out_ready = ~task_out_ready;
    end

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); reg_wvalid = 1; reg_waddr = a; reg_wdata = d;
        @(negedge clk); reg_wvalid = 0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk); reg_arvalid = 1; reg_araddr = a;
        @(negedge clk); reg_arvalid = 0;
        chk("reg_rvalid", {63'd0, reg_rvalid}, 64'd1);
        d = reg_rdata;
    endtask

    task automatic configure();
        reg_write(8'h20, 32'h100);
        reg_write(8'h24, 32'h200);
        reg_write(8'h28, 32'h300);
        reg_write(8'h2C, 32'h400);
        reg_write(8'h00, 32'h8);
    endtask

    task automatic send(input logic [15:0] coal);
        bit ok = 0;
        for (int i = 0; i < 8; i++)
            exp_q.push_back(task_val(32'h4000 + ({16'h0, coal} << 6) + 32'(i * 8)));
        @(negedge clk); task_in_valid = 1; task_in = {32'h0, coal, 16'h0};
        for (int i = 0; i < 100 && !ok; i++) begin
            if (task_in_ready) ok = 1;
            else @(negedge clk);
        end
        @(posedge clk); #1 task_in_valid = 0;
        if (!ok) begin n_chk++; n_fail++; $display("FAIL send_timeout: got ready=0, required ready=1"); end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (task_in_ready) ok = 1;
        end
        chk({name, "_idle"}, {63'd0, ok}, 64'd1);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input string name, input logic [15:0] coal);
        wl_addr.delete(); wl_data.delete(); lock_seen = 0;
        send(coal);
        wait_idle(name);
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [31:0] a, input logic [63:0] d);
        if (wl_addr.size() > idx) begin
            chk({name, "_waddr"}, {32'h0, wl_addr[idx]}, {32'h0, a});
            chk({name, "_wdata"}, wl_data[idx], d);
        end else begin
            n_chk++; n_fail++;
            $display("FAIL %s_missing_write: got %0d writes, required write %0d", name, wl_addr.size(), idx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int hs0;
        bit ok;
        logic [15:0] coals [7] = '{16'h12, 16'h13, 16'h27, 16'h2F, 16'h37, 16'h3F, 16'h01};
        foreach (coals[k])
            for (int i = 0; i < 8; i++) begin
                logic [31:0] a;
                a = 32'h4000 + ({16'h0, coals[k]} << 6) + 32'(i * 8);
                mem[a] = task_val(a);
            end
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        #1;
        chk("rst_task_in_ready", {63'd0, task_in_ready}, 64'd0);
        chk("rst_task_out_valid", {63'd0, task_out_valid}, 64'd0);
        chk("rst_lock", {63'd0, stack_lock_out}, 64'd0);
        chk("rst_arvalid", {63'd0, l1_arvalid}, 64'd0);
        reg_read(8'h04, rd);
        chk("rst_core_state", {32'h0, rd}, 64'd0);
        configure();
        #1 chk("start_ready", {63'd0, task_in_ready}, 64'd1);

        // slot 2 of chunk 2, bitmap not complete
        run("t1", 16'h12);
        chk("t1_nwr", 64'(wl_addr.size()), 64'd1);
        chk_wr("t1_scr", 0, 32'hC008, 64'h4);
        chk("t1_no_lock", {63'd0, lock_seen}, 64'd0);

        // backpressure toggling during the burst
        hs0 = n_hs; tog_en = 1;
        run("t2", 16'h13);
        tog_en = 0; #1 task_out_ready = 1;
        chk("t2_count", 64'(n_hs - hs0), 64'd8);
        chk_wr("t2_scr", 0, 32'hC008, 64'hC);

        // final slot of chunk 4, ptr 5
        mem[32'hC010] = 64'h7F; mem[32'h10000] = 64'd5;
        run("t3", 16'h27);
        chk("t3_nwr", 64'(wl_addr.size()), 64'd3);
        chk_wr("t3_scr", 0, 32'hC010, 64'h0);
        chk_wr("t3_entry", 1, 32'h8008, 64'd4);
        chk_wr("t3_ptr", 2, 32'h10000, 64'd4);
        chk("t3_lock_seen", {63'd0, lock_seen}, 64'd1);
        chk("t3_lock_rel", {63'd0, stack_lock_out}, 64'd0);

        // coalescer holds the lock: splitter must wait
        mem[32'hC014] = 64'h7F; stack_lock_in = 1;
        fork
            run("t4a", 16'h2F);
            begin
                ok = 0;
                for (int i = 0; i < 500 && !ok; i++) begin
                    @(negedge clk);
                    if (wl_addr.size() >= 1) ok = 1;
                end
                repeat (10) @(negedge clk);
                chk("t4a_wait_lock", {63'd0, stack_lock_out}, 64'd0);
                chk("t4a_wait_nwr", 64'(wl_addr.size()), 64'd1);
                stack_lock_in = 0;
            end
        join
        chk_wr("t4a_entry", 1, 32'h8006, 64'd5);
        chk_wr("t4a_ptr", 2, 32'h10000, 64'd3);

        // coalescer requests right as splitter takes the lock: splitter keeps it
        mem[32'hC018] = 64'h7F;
        fork
            run("t4b", 16'h37);
            begin
                ok = 0;
                for (int i = 0; i < 500 && !ok; i++) begin
                    @(negedge clk);
                    if (stack_lock_out) ok = 1;
                end
                stack_lock_in = 1;
            end
        join
        stack_lock_in = 0;
        chk("t4b_nwr", 64'(wl_addr.size()), 64'd3);
        chk_wr("t4b_entry", 1, 32'h8004, 64'd6);
        chk_wr("t4b_ptr", 2, 32'h10000, 64'd2);
        chk("t4b_lock_rel", {63'd0, stack_lock_out}, 64'd0);

        // stack underflow
        mem[32'hC01C] = 64'h7F; mem[32'h10000] = 64'd0;
        run("t5", 16'h3F);
        chk("t5_nwr", 64'(wl_addr.size()), 64'd1);
        chk_wr("t5_scr", 0, 32'hC01C, 64'h0);
        reg_read(8'h04, rd);
        chk("t5_err", {32'h0, rd}, 64'h10);
        reg_read(8'h08, rd);
        chk("stats_absent", {32'h0, rd}, 64'd0);

        // async reset in the middle of the task burst
        wl_addr.delete(); wl_data.delete();
        hs0 = n_hs;
        send(16'h01);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (n_hs != hs0) ok = 1;
        end
        chk("t6_burst_started", {63'd0, ok}, 64'd1);
        @(posedge clk); #2 rstn = 0;
        #1;
        chk("t6_task_out_valid", {63'd0, task_out_valid}, 64'd0);
        chk("t6_rready", {63'd0, l1_rready}, 64'd0);
        chk("t6_lock", {63'd0, stack_lock_out}, 64'd0);
        chk("t6_task_in_ready", {63'd0, task_in_ready}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        reg_read(8'h04, rd);
        chk("t6_state_cleared", {32'h0, rd}, 64'd0);
        chk("t6_nwr_aborted", 64'(wl_addr.size()), 64'd0);
        configure();
        run("t6", 16'h01);
        chk("t6_nwr", 64'(wl_addr.size()), 64'd1);
        chk_wr("t6_scr", 0, 32'hC000, 64'h2);

        reg_write(8'h00, 32'h0);
        #1 chk("stop_ready", {63'd0, task_in_ready}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
